// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with programmable latency and LL/SC reservation
module dmem_responder #(
    parameter int BITS      = 32,
    parameter int WORDS     = 256,
    parameter int BASE_ADDR = 0,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [BITS-1:0] req_addr,
    input  logic [BITS-1:0] req_wdata,
    input  logic            req_rw_,
    input  logic [3:0]      req_byte_en,
    input  logic            req_ll_,
    input  logic            req_sc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_rdata,
    output logic            rsp_sc_ok,
    output logic            rsp_err,
    input  logic            snoop_wr,
    input  logic [BITS-1:0] snoop_addr,
    output logic            link_valid,
    output logic [BITS-1:0] link_addr
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BITS-1:0] BASE    = BITS'(BASE_ADDR);
    localparam logic [BITS-1:0] WORDS_L = BITS'(WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] q_addr;
    logic [BITS-1:0] q_wdata;
    logic            q_rw_;
    logic [3:0]      q_be;
    logic            q_ll_;
    logic            q_sc;

    logic [BITS-1:0] mem [WORDS];

    logic            commit;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic            snoop_hit;
    logic            link_match;
    logic            do_write;
    logic [BITS-1:0] cur;
    logic [BITS-1:0] wmerge;

    assign req_ready = rst_ && (state == IDLE);

    always_comb begin
        commit     = (state == WAIT) && (cnt == '0);
        in_range   = (q_addr >= BASE) && ((q_addr - BASE) < WORDS_L);
        idx        = AW'(q_addr - BASE);
        cur        = mem[idx];
        // The snoop is evaluated ahead of a same-edge SC, so a hit kills the SC.
        snoop_hit  = snoop_wr && (snoop_addr == link_addr);
        link_match = link_valid && (link_addr == q_addr) && !snoop_hit;
        do_write   = commit && in_range && !q_rw_ && (!q_sc || link_match);
        wmerge     = cur;
        for (int i = 0; i < 4; i++) begin
            if (q_be[i]) begin
                wmerge[8*i +: 8] = q_wdata[8*i +: 8];
            end
        end
    end

    // Array has no reset; commits cannot occur while rst_ is low since state is IDLE.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= wmerge;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            cnt        <= '0;
            q_addr     <= '0;
            q_wdata    <= '0;
            q_rw_      <= 1'b1;
            q_be       <= '0;
            q_ll_      <= 1'b1;
            q_sc       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_sc_ok  <= 1'b0;
            rsp_err    <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (snoop_hit) begin
                link_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        q_addr  <= req_addr;
                        q_wdata <= req_wdata;
                        q_rw_   <= req_rw_;
                        q_be    <= req_byte_en;
                        q_ll_   <= req_ll_;
                        q_sc    <= req_sc;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !in_range;
                        rsp_rdata <= (in_range && q_rw_) ? cur : '0;
                        rsp_sc_ok <= in_range && !q_rw_ && q_sc && link_match;
                        if (!in_range) begin
                            if (!q_rw_ && q_sc) begin
                                link_valid <= 1'b0;
                            end
                        end else if (q_rw_) begin
                            if (!q_ll_) begin
                                link_addr  <= q_addr;
                                link_valid <= 1'b1;
                            end
                        end else if (q_sc) begin
                            link_valid <= 1'b0;
                        end else if (link_addr == q_addr) begin
                            link_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_sc_ok <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int BITS    = 32;
    localparam int WORDS   = 256;
    localparam int LATENCY = 2;

    logic            clk = 1'b0;
    logic            rst_ = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [BITS-1:0] req_addr = '0;
    logic [BITS-1:0] req_wdata = '0;
    logic            req_rw_ = 1'b1;
    logic [3:0]      req_byte_en = '0;
    logic            req_ll_ = 1'b1;
    logic            req_sc = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [BITS-1:0] rsp_rdata;
    logic            rsp_sc_ok;
    logic            rsp_err;
    logic            snoop_wr = 1'b0;
    logic [BITS-1:0] snoop_addr = '0;
    logic            link_valid;
    logic [BITS-1:0] link_addr;

    dmem_responder #(.BITS(BITS), .WORDS(WORDS), .BASE_ADDR(0), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw_(req_rw_), .req_byte_en(req_byte_en),
        .req_ll_(req_ll_), .req_sc(req_sc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_sc_ok(rsp_sc_ok), .rsp_err(rsp_err),
        .snoop_wr(snoop_wr), .snoop_addr(snoop_addr),
        .link_valid(link_valid), .link_addr(link_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BITS-1:0] rdata;
        logic            sc_ok;
        logic            err;
    } rsp_t;

    rsp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [BITS-1:0] mdl [WORDS];
    logic            mlv = 1'b0;
    logic [BITS-1:0] mla = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_sc_ok", rsp_sc_ok, e.sc_ok);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic txn(input logic rw, input logic ll, input logic sc, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] wd, input logic [3:0] be, input int snoop_at, input int hold);
        rsp_t e;
        int lat;
        int n;
        logic [BITS-1:0] nw;
        e = '0;
        if (snoop_at > 0 && a == mla) mlv = 1'b0;
        if (a >= WORDS) begin
            e.err = 1'b1;
            if (!rw && sc) mlv = 1'b0;
        end else if (rw) begin
            e.rdata = mdl[a];
            if (!ll) begin
                mla = a;
                mlv = 1'b1;
            end
        end else begin
            nw = mdl[a];
            for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
            if (sc) begin
                e.sc_ok = mlv && (mla == a);
                if (e.sc_ok) mdl[a] = nw;
                mlv = 1'b0;
            end else begin
                mdl[a] = nw;
                if (mla == a) mlv = 1'b0;
            end
        end
        sb.push_back(e);

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_rw_ = rw; req_ll_ = ll; req_sc = sc;
        req_addr = a; req_wdata = wd; req_byte_en = be;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (lat + 1 == snoop_at) begin
                snoop_wr = 1'b1;
                snoop_addr = a;
            end
            @(posedge clk);
            lat++;
            #1 snoop_wr = 1'b0;
        end
        check("latency", lat, LATENCY);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_req_ready", req_ready, 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        n = 0;
        while (rsp_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("rsp_drop", rsp_valid, 0);
        check("link_valid", link_valid, mlv);
        if (mlv) check("link_addr", link_addr, mla);
    endtask

    initial begin
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_rdata", rsp_rdata, 0);
        check("post_rst_link", link_valid, 0);

        txn(0, 1, 0, 5, 32'hDEADBEEF, 4'hF, 0, 0);
        txn(1, 1, 0, 5, 0, 4'h0, 0, 0);

        txn(0, 1, 0, 10, 32'h11223344, 4'hF, 0, 0);
        txn(0, 1, 0, 10, 32'hAABBCCDD, 4'b0101, 0, 0);
        txn(1, 1, 0, 10, 0, 4'h0, 0, 0);
        check("partial_model", mdl[10], 32'h11BB33DD);

        txn(0, 1, 0, 8, 32'h0, 4'hF, 0, 0);
        txn(1, 0, 0, 8, 0, 4'h0, 0, 0);
        txn(0, 1, 1, 8, 32'h1, 4'hF, 0, 0);
        txn(0, 1, 1, 8, 32'h2, 4'hF, 0, 0);
        txn(1, 1, 0, 8, 0, 4'h0, 0, 0);

        txn(1, 0, 0, 8, 0, 4'h0, 0, 0);
        txn(0, 1, 1, 8, 32'h3, 4'hF, 1, 0);
        txn(1, 0, 0, 8, 0, 4'h0, 0, 0);
        txn(0, 1, 1, 8, 32'h4, 4'hF, LATENCY, 0);
        txn(1, 1, 0, 8, 0, 4'h0, 0, 0);
        txn(1, 0, 0, 8, 0, 4'h0, LATENCY, 0);

        txn(0, 1, 0, 9, 32'h9, 4'hF, 0, 0);
        txn(0, 1, 0, 8, 32'h5, 4'h0, 0, 0);
        txn(1, 1, 0, 8, 0, 4'h0, 0, 0);

        txn(1, 1, 0, WORDS, 0, 4'h0, 0, 5);
        txn(0, 1, 1, WORDS + 3, 32'h7, 4'hF, 0, 0);

        txn(0, 1, 0, 3, 32'h0, 4'hF, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_rw_ = 1'b0; req_ll_ = 1'b1; req_sc = 1'b0;
        req_addr = 3; req_wdata = 32'h55AA55AA; req_byte_en = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rdata", rsp_rdata, 0);
        check("midrst_sc_ok", rsp_sc_ok, 0);
        check("midrst_err", rsp_err, 0);
        check("midrst_link_valid", link_valid, 0);
        check("midrst_link_addr", link_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        mlv = 1'b0;
        mla = '0;
        txn(1, 1, 0, 3, 0, 4'h0, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
